cpu_controller: RTL

- Sequencing controller for the VeriRISC CPU; the counterpart to the ALU.
- Consumes the 3-bit opcode from the instruction register and the ALU `zero` flag. Produces every datapath control strobe: mux select, memory read/write, IR/PC/accumulator loads, PC increment and halt.
- Steps through a fixed 8-phase instruction cycle on rising clk edges, so the negedge-clocked ALU sees stable control and operands.

---
 rtl/cpu_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// VeriRISC sequencing controller: 8-phase instruction cycle, combinational strobe decode
// from the registered phase, sticky halt and a retired-instruction counter.
module cpu_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             ld_ac,
    output logic             data_e,
    output logic             wr,
    output logic             halt,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t           r_phase;
    logic             r_halted;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_aluop;
    logic w_is_hlt;

    assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign w_is_hlt = (opcode == OP_HLT);

    // HLT freezes the phase at OP_ADDR; an X opcode is not HLT, so the phase keeps moving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= INST_ADDR;
            r_halted    <= 1'b0;
            r_instr_cnt <= '0;
        end else if (!r_halted) begin
            if (r_phase == OP_ADDR && w_is_hlt) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= phase_t'(r_phase + 3'd1);
                if (r_phase == STORE)
                    r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_is_hlt;
                end
                OP_FETCH: begin
                    rd = w_aluop;
                end
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase     = r_phase;
    assign instr_cnt = r_instr_cnt;

    // Opcode-dependent strobes are only meaningful with a known opcode in phases 4-7.
    a_opcode_known: assert property (@(posedge clk) disable iff (rst)
        (r_phase[2] && !r_halted) |-> !$isunknown(opcode));

endmodule
